// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the SRAM note prefetch stage.
// The SRAM is only ever read, so its control pins are fixed.
package sram_pkg;
   localparam int          ADDR_W_DEF   = 18;
   localparam logic [15:0] END_WORD_DEF = 16'hFFFF;

   localparam logic SRAM_WE_VAL = 1'b1;
   localparam logic SRAM_CE_VAL = 1'b0;
   localparam logic SRAM_OE_VAL = 1'b0;
   localparam logic SRAM_LB_VAL = 1'b0;
   localparam logic SRAM_UB_VAL = 1'b0;

   typedef enum logic [1:0] {IDLE, WAIT, STALL, HALT} fetch_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head word, so the consumer
// sees data straight from a flop.
module sync_fifo #(
   parameter  int DEPTH = 4,
   parameter  int DW    = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   logic [DEPTH-1:0][DW-1:0] mem;
   logic [AW-1:0]            wr_ptr, rd_ptr;
   logic                     do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         // Head tracks the word that will be at rd_ptr after this edge;
         // with a single entry left, that is the word being pushed.
         if (do_pop)
            head <= (count > CW'(1)) ? mem[rd_ptr + 1'b1] : din;
         else if (empty && do_push)
            head <= din;
      end
   end
endmodule

// File: rtl/sram_note_fetch.sv
// Streams note words from async SRAM into a FIFO until the end-of-song
// marker; one read in flight, issued only when a FIFO slot is guaranteed.
module sram_note_fetch
   import sram_pkg::*;
#(
   parameter int          ADDR_W    = ADDR_W_DEF,
   parameter int          DEPTH     = 4,
   parameter int          READ_WAIT = 2,
   parameter logic [15:0] END_WORD  = END_WORD_DEF
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   input  logic [ADDR_W-1:0] START_ADDR,
   output logic [ADDR_W-1:0] SRAM_A,
   input  logic [15:0]       SRAM_D,
   output logic              SRAM_WE,
   output logic              SRAM_CE,
   output logic              SRAM_OE,
   output logic              SRAM_LB,
   output logic              SRAM_UB,
   output logic              INS_VALID,
   output logic [15:0]       INS_DATA,
   input  logic              INS_READY,
   output logic              DONE,
   output logic [ADDR_W-1:0] PC
);
   localparam int WCW = $clog2(READ_WAIT + 1);
   localparam int CW  = $clog2(DEPTH) + 1;

   fetch_state_e      state, state_nxt;
   logic [WCW-1:0]    wcnt, wcnt_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt, addr, addr_nxt;
   logic              done, done_nxt;
   logic              push, flush, pop, capture, room;
   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count, occ_push;

   assign pop      = INS_READY & ~fifo_empty;
   assign capture  = (state == WAIT) && (wcnt == WCW'(READ_WAIT));
   // Occupancy after an edge that pushes, with any pop applied.
   assign occ_push = fifo_count + CW'(1) - CW'(pop);
   assign room     = (occ_push < CW'(DEPTH));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         wcnt  <= '0;
         pc    <= '0;
         addr  <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         pc    <= pc_nxt;
         addr  <= addr_nxt;
         done  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      pc_nxt    = pc;
      addr_nxt  = addr;
      done_nxt  = done;
      push      = 1'b0;
      flush     = 1'b0;
      if (START) begin
         flush     = 1'b1;
         addr_nxt  = START_ADDR;
         pc_nxt    = START_ADDR;
         done_nxt  = 1'b0;
         wcnt_nxt  = '0;
         state_nxt = WAIT;
      end else begin
         case (state)
            IDLE: ;
            WAIT: begin
               if (!capture)
                  wcnt_nxt = wcnt + 1'b1;
               else if (SRAM_D == END_WORD) begin
                  done_nxt  = 1'b1;
                  state_nxt = HALT;
               end else begin
                  push     = 1'b1;
                  pc_nxt   = pc + ADDR_W'(1);
                  addr_nxt = pc + ADDR_W'(1);
                  wcnt_nxt = '0;
                  if (!room)
                     state_nxt = STALL;
               end
            end
            STALL: begin
               if (!fifo_full || pop) begin
                  addr_nxt  = pc;
                  wcnt_nxt  = '0;
                  state_nxt = WAIT;
               end
            end
            HALT: ;
            default: state_nxt = IDLE;
         endcase
      end
   end

   sync_fifo #(.DEPTH(DEPTH), .DW(16)) u_fifo (
      .CLK   (CLK),
      .RST_N (RST_N),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   (SRAM_D),
      .head  (INS_DATA),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign SRAM_A    = addr;
   assign PC        = pc;
   assign DONE      = done;
   assign INS_VALID = ~fifo_empty;
   assign SRAM_WE   = SRAM_WE_VAL;
   assign SRAM_CE   = SRAM_CE_VAL;
   assign SRAM_OE   = SRAM_OE_VAL;
   assign SRAM_LB   = SRAM_LB_VAL;
   assign SRAM_UB   = SRAM_UB_VAL;
endmodule

// File: doc/sram_note_fetch.md
# sram_note_fetch

Prefetch stage that streams 16-bit note instructions out of the external asynchronous SRAM into a small FIFO and presents them to the note player over a valid/ready handshake. It owns the SRAM read sequencing: address issue, access wait, data capture and program-counter increment. The player no longer has to time SRAM reads inside its beat counter; it pops one instruction per beat. Fetching stops at an end-of-song marker word.

## Interface
- ADDR_W, 18: SRAM address width.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- READ_WAIT, 2: cycles the address is held before the data sampling edge; at least 1.
- END_WORD, 16'hFFFF: end-of-song marker; never delivered.

- CLK  in  1  50 MHz system clock; all state updates on its rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- START  in  1  one-cycle pulse: flush the FIFO and begin fetching at START_ADDR.
- START_ADDR  in  ADDR_W  first instruction address, sampled with START.
- SRAM_A  out  ADDR_W  registered read address.
- SRAM_D  in  16  SRAM read data.
- SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB  out  1 each  constant 1,0,0,0,0: read-only, full word.
- INS_VALID  out  1  FIFO non-empty.
- INS_DATA  out  16  FIFO head word; meaningful only while INS_VALID is high.
- INS_READY  in  1  consumer pop; a pop occurs on an edge where INS_VALID and INS_READY are both high.
- DONE  out  1  END_WORD has been fetched. Stays high until the next START or reset.
- PC  out  ADDR_W  address of the next word to fetch.

## Operation
- States:
  - IDLE: the post-reset state.
  - WAIT: a read is in flight. A wait counter runs from 0 to READ_WAIT.
  - STALL: the FIFO is full and the next address is held.
  - HALT: END_WORD has been seen.
- IDLE, on START:
  - SRAM_A <= START_ADDR and PC <= START_ADDR.
  - Flush the FIFO, clear DONE, reset the wait counter, go to WAIT.
- WAIT: the counter increments each cycle. The edge on which the counter equals READ_WAIT is the capture edge.
- Capture edge, SRAM_D == END_WORD: no push, DONE <= 1, go to HALT.
- Capture edge, any other word:
  - Push SRAM_D and set PC <= PC+1.
  - If the FIFO occupancy after this edge (push and pop both applied) is below DEPTH: SRAM_A <= PC+1, counter <= 0, stay in WAIT.
  - Otherwise go to STALL.
- STALL: on the first edge where occupancy is below DEPTH, SRAM_A <= PC, counter <= 0, go to WAIT.
- HALT: no further reads. The FIFO keeps draining normally.
- Occupancy rules:
  - At most one read is in flight.
  - A read is issued only if a slot is guaranteed, so a push never overflows.
  - Simultaneous push and pop leave the count unchanged.
  - A pop while empty is ignored.
- Address arithmetic is modulo 2^ADDR_W: PC 18'h3FFFF wraps to 0.
- START in any state aborts the in-flight read (its data is discarded), flushes the FIFO and restarts as from IDLE. START has priority over capture and pop on the same edge.
- Reset, including mid-read: state IDLE, SRAM_A 0, PC 0, FIFO empty, INS_VALID 0, INS_DATA 0, DONE 0. The SRAM control pins keep their constant values.

## Timing
- START sampled at edge E0: SRAM_A is valid after E0, SRAM_D is sampled at edge E0+READ_WAIT+1, and INS_VALID rises after that edge. With the default, INS_VALID rises 3 cycles after START.
- Steady-state fetch rate: one word per READ_WAIT+1 cycles while the FIFO has room.
- INS_DATA and INS_VALID come from registers: no combinational path from SRAM_D or INS_READY.
- DONE rises after the capture edge of END_WORD. Words before the marker remain poppable.

## Structure
- Shared package sram_pkg holds:
  - ADDR_W default and END_WORD.
  - The SRAM control constants.
  - The state enum (IDLE, WAIT, STALL, HALT).
- One sub-module, sync_fifo:
  - DEPTH x 16 register array with pointers and a count.
  - Push/pop/flush inputs; full/empty/count outputs.
  - Head data is registered.
- The top level holds the state machine, wait counter, PC and SRAM_A register.

## Test plan
- SRAM model with 0x1005, 0x0023, 0xFFFF at address 0; START with START_ADDR 0; INS_READY held 1 -> INS_DATA shows 0x1005 then 0x0023, each one cycle valid. DONE rises after the address-2 capture. SRAM_A never exceeds 2.
- INS_READY held 0 with 10 non-marker words -> exactly 4 words are buffered, the state stays STALL with SRAM_A 4 and PC 4. Raise INS_READY -> words 0..9 arrive in order with none lost or duplicated.
- START_ADDR 18'h3FFFE, marker at address 1 -> SRAM_A sequence is 3FFFE, 3FFFF, 0, 1. Three words are delivered.
- START pulsed in the second cycle of a WAIT -> in-flight data is dropped, the FIFO is empty next cycle, and SRAM_A equals the new START_ADDR.
- RST_N asserted mid-read, then released -> INS_VALID 0, DONE 0, SRAM_A 0 immediately. No reads occur until START.
- READ_WAIT=1 and READ_WAIT=3 builds -> the first INS_VALID appears 2 and 4 cycles after START respectively.
